// File: rtl/pos_stepper_ctrl_if.sv
// Waypoint handshake between the plotter motion controller (master) and the
// flash-to-position converter (slave): one-cycle request, one-cycle done strobe.
interface pos_stepper_ctrl_if;
    logic       oPOS_REQUEST;
    logic [8:0] iX;
    logic [8:0] iY;
    logic       iDone;
    logic       iDown;

    modport master (output oPOS_REQUEST, input iX, input iY, input iDone, input iDown);
    modport slave  (input oPOS_REQUEST, output iX, output iY, output iDone, output iDown);
endinterface

// File: rtl/pos_stepper_ctrl.sv
// Pen-plotter motion controller: pulls waypoints, steps two axes, drives the pen
// servo and parks at (0,0) on the 511/511 sentinel. Optional macro: POS_TRACE_EN.
module pos_stepper_ctrl #(
    parameter int STEP_HALF  = 2500,
    parameter int PEN_SETTLE = 500000
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iStart,
    pos_stepper_ctrl_if.master        pos,
    output logic                      oX_STEP,
    output logic                      oY_STEP,
    output logic                      oX_DIR,
    output logic                      oY_DIR,
    output logic                      oPEN,
    output logic                      oBusy,
    output logic                      oFinish,
    output logic [14:0]               oTest
);

    localparam int CNT_MAX = (2 * STEP_HALF > PEN_SETTLE) ? 2 * STEP_HALF : PEN_SETTLE;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] PERIOD_LAST = CW'(2 * STEP_HALF - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(PEN_SETTLE - 1);
    localparam logic [CW-1:0] HALF        = CW'(STEP_HALF);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_MOVE, S_PEN, S_PARK_PEN, S_PARK_MOVE, S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [8:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [8:0]    tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic          tgt_down_q, tgt_down_d;
    logic          pen_q, pen_d;
    logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic sentinel;
    logic capture;
    logic is_move;
    assign sentinel = (pos.iX == 9'd511) && (pos.iY == 9'd511);
    assign capture  = (state_q == S_WAIT) && iStart && pos.iDone;
    assign is_move  = (state_q == S_MOVE) || (state_q == S_PARK_MOVE);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q    <= S_IDLE;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            tgt_x_q    <= '0;
            tgt_y_q    <= '0;
            tgt_down_q <= 1'b0;
            pen_q      <= 1'b0;
            dir_x_q    <= 1'b0;
            dir_y_q    <= 1'b0;
            run_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            tgt_down_q <= tgt_down_d;
            pen_q      <= pen_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            run_q      <= run_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        tgt_down_d = tgt_down_q;
        pen_d      = pen_q;
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        run_d      = run_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: if (iStart) state_d = S_REQ;
            S_REQ:  state_d = iStart ? S_WAIT : S_PARK_PEN;
            S_WAIT: begin
                // Abort wins over a strobe arriving in the same cycle.
                if (!iStart) begin
                    state_d = S_PARK_PEN;
                end else if (pos.iDone) begin
                    tgt_x_d    = pos.iX;
                    tgt_y_d    = pos.iY;
                    tgt_down_d = pos.iDown;
                    state_d    = sentinel ? S_PARK_PEN : S_MOVE;
                end
            end
            S_MOVE, S_PARK_MOVE: begin
                if (!run_q) begin
                    if (cur_x_q == tgt_x_q && cur_y_q == tgt_y_q)
                        state_d = (state_q == S_MOVE) ? S_PEN : S_FIN;
                    else
                        run_d = 1'b1;
                end else if (cnt_q == PERIOD_LAST) begin
                    cnt_d = '0;
                    if (cur_x_q != tgt_x_q) cur_x_d = dir_x_q ? cur_x_q + 9'd1 : cur_x_q - 9'd1;
                    if (cur_y_q != tgt_y_q) cur_y_d = dir_y_q ? cur_y_q + 9'd1 : cur_y_q - 9'd1;
                    if (cur_x_d == tgt_x_q && cur_y_d == tgt_y_q)
                        state_d = (state_q == S_MOVE) ? S_PEN : S_FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PEN, S_PARK_PEN: begin
                // First cycle decides whether the pen moves; settling runs afterwards.
                if (!run_q) begin
                    if (pen_q == ((state_q == S_PEN) ? tgt_down_q : 1'b0)) begin
                        state_d = (state_q == S_PEN) ? S_REQ : S_PARK_MOVE;
                    end else begin
                        pen_d = (state_q == S_PEN) ? tgt_down_q : 1'b0;
                        run_d = 1'b1;
                    end
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = (state_q == S_PEN) ? S_REQ : S_PARK_MOVE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (state_d == S_PARK_MOVE) begin
                    tgt_x_d = '0;
                    tgt_y_d = '0;
                end
            end
            S_FIN:   if (!iStart) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            run_d = 1'b0;
            cnt_d = '0;
        end
        // Direction is latched on entry so it is already valid in the first move cycle.
        if ((state_d == S_MOVE || state_d == S_PARK_MOVE) && state_d != state_q) begin
            if (tgt_x_d > cur_x_q)      dir_x_d = 1'b1;
            else if (tgt_x_d < cur_x_q) dir_x_d = 1'b0;
            if (tgt_y_d > cur_y_q)      dir_y_d = 1'b1;
            else if (tgt_y_d < cur_y_q) dir_y_d = 1'b0;
        end
    end

    always_comb begin
        pos.oPOS_REQUEST = (state_q == S_REQ);
        oX_STEP = is_move && run_q && (cnt_q < HALF) && (cur_x_q != tgt_x_q);
        oY_STEP = is_move && run_q && (cnt_q < HALF) && (cur_y_q != tgt_y_q);
        oX_DIR  = dir_x_q;
        oY_DIR  = dir_y_q;
        oPEN    = pen_q;
        oBusy   = (state_q != S_IDLE) && (state_q != S_FIN);
        oFinish = (state_q == S_FIN);
    end

`ifdef POS_TRACE_EN
    logic [14:0] trace_q, trace_d;

    always_comb begin
        trace_d = trace_q;
        if (state_q == S_IDLE && iStart)
            trace_d = '0;
        else if (capture && !sentinel && trace_q != 15'h7fff)
            trace_d = trace_q + 15'd1;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) trace_q <= '0;
        else       trace_q <= trace_d;
    end

    assign oTest = trace_q;
`else
    assign oTest = '0;
`endif

endmodule

// File: tb/tb_pos_stepper_ctrl.sv
// Directed bench for pos_stepper_ctrl: a cycle-level expectation stream built from
// move/settle arithmetic, checked on every falling edge, plus pinned literal values.
module tb_pos_stepper_ctrl;
    localparam int H = 2;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic xs, ys, xd, yd, pen, busy, fin;
    logic [14:0] test;

    pos_stepper_ctrl_if pos_if();

    pos_stepper_ctrl #(.STEP_HALF(H), .PEN_SETTLE(S)) dut (
        .iCLK(clk), .iRST(rst_n), .iStart(start), .pos(pos_if),
        .oX_STEP(xs), .oY_STEP(ys), .oX_DIR(xd), .oY_DIR(yd),
        .oPEN(pen), .oBusy(busy), .oFinish(fin), .oTest(test)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [22:0] exp_q[$];
    string lit_name_q[$];
    int lit_act_q[$];
    int lit_exp_q[$];

    // model state
    int   m_x = 0, m_y = 0, m_test = 0, last_move_len = 0;
    logic m_pen = 1'b0, m_xd = 1'b0, m_yd = 1'b0;
`ifdef POS_TRACE_EN
    localparam int TRACE_RUN1 = 3;
`else
    localparam int TRACE_RUN1 = 0;
`endif

    // rising-edge counters on the step outputs
    int xcnt = 0, ycnt = 0;
    logic px = 1'b0, py = 1'b0;
    always @(negedge clk) begin
        if (xs && !px) xcnt++;
        if (ys && !py) ycnt++;
        px = xs;
        py = ys;
    end

    logic [22:0] e_v, a_v;
    string l_n;
    int l_a, l_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_v = exp_q.pop_front();
            a_v = {pos_if.oPOS_REQUEST, xs, ys, xd, yd, pen, busy, fin, test};
            checks++;
            if (a_v !== e_v) begin
                errors++;
                $display("FAIL outputs t=%0t got=%h want=%h (req,xs,ys,xd,yd,pen,busy,fin,test)",
                         $time, a_v, e_v);
            end
        end
        while (lit_name_q.size() > 0) begin
            l_n = lit_name_q.pop_front();
            l_a = lit_act_q.pop_front();
            l_e = lit_exp_q.pop_front();
            checks++;
            if (l_a != l_e) begin
                errors++;
                $display("FAIL %s got=%0d want=%0d", l_n, l_a, l_e);
            end
        end
    end

    task automatic lit(input string n, input int a, input int e);
        lit_name_q.push_back(n);
        lit_act_q.push_back(a);
        lit_exp_q.push_back(e);
        $display("check %s value=%0d expected=%0d", n, a, e);
    endtask

    // Record what the current cycle must show, then advance to the next cycle.
    task automatic cyc(input logic req, input logic sx, input logic sy, input logic bsy, input logic fn);
        exp_q.push_back({req, sx, sy, m_xd, m_yd, m_pen, bsy, fn, 15'(m_test)});
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_busy();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic cyc_idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic trace_inc();
`ifdef POS_TRACE_EN
        if (m_test != 32767) m_test++;
`endif
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // A move is one setup cycle then max(|dX|,|dY|) step periods of 2*H cycles;
    // an axis pulses during the first H cycles of each period it still has to travel.
    task automatic move(input int tx, input int ty, input int limit);
        int dx, dy, n, tot, p, ph;
        logic sx, sy;
        if (tx > m_x) m_xd = 1'b1; else if (tx < m_x) m_xd = 1'b0;
        if (ty > m_y) m_yd = 1'b1; else if (ty < m_y) m_yd = 1'b0;
        dx = iabs(tx - m_x);
        dy = iabs(ty - m_y);
        n = (dx > dy) ? dx : dy;
        tot = 1 + 2 * H * n;
        last_move_len = tot;
        for (int c = 0; c < tot && c < limit; c++) begin
            sx = 1'b0;
            sy = 1'b0;
            if (c > 0) begin
                p  = (c - 1) / (2 * H);
                ph = (c - 1) % (2 * H);
                sx = (p < dx) && (ph < H);
                sy = (p < dy) && (ph < H);
            end
            cyc(1'b0, sx, sy, 1'b1, 1'b0);
        end
        if (limit >= tot) begin
            m_x = tx;
            m_y = ty;
        end
    endtask

    task automatic pen_phase(input logic down);
        cyc_busy();
        if (m_pen != down) begin
            m_pen = down;
            repeat (S) cyc_busy();
        end
    endtask

    task automatic park();
        pen_phase(1'b0);
        move(0, 0, 100000);
    endtask

    // Starts in the REQ cycle; ends in the next REQ cycle (or FIN after the sentinel).
    task automatic respond(input int delay, input int x, input int y, input logic down);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (delay - 1) cyc_busy();
        pos_if.iDone = 1'b1;
        pos_if.iX = 9'(x);
        pos_if.iY = 9'(y);
        pos_if.iDown = down;
        cyc_busy();
        pos_if.iDone = 1'b0;
        if (x == 511 && y == 511) begin
            park();
        end else begin
            trace_inc();
            move(x, y, 100000);
            pen_phase(down);
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        cyc_idle();
        m_test = 0;
    endtask

    int bx, by;
    initial begin
        pos_if.iDone = 1'b0;
        pos_if.iX = '0;
        pos_if.iY = '0;
        pos_if.iDown = 1'b0;
        @(posedge clk);
        #1;
        cyc_idle();
        cyc_idle();
        rst_n = 1'b1;
        cyc_idle();
        cyc_idle();

        // Run 1: three waypoints then the sentinel
        start_run();
        lit("req_first", pos_if.oPOS_REQUEST, 1);
        bx = xcnt; by = ycnt;
        respond(5, 3, 1, 1'b1);
        lit("move_len_wp1", last_move_len, 13);
        lit("x_pulses_wp1", xcnt - bx, 3);
        lit("y_pulses_wp1", ycnt - by, 1);
        lit("pen_wp1", pen, 1);
        lit("req_after_settle", pos_if.oPOS_REQUEST, 1);
        bx = xcnt; by = ycnt;
        respond(1, 0, 1, 1'b0);
        lit("x_pulses_wp2", xcnt - bx, 3);
        lit("y_pulses_wp2", ycnt - by, 0);
        lit("x_dir_wp2", xd, 0);
        respond(2, 5, 5, 1'b1);
        bx = xcnt; by = ycnt;
        respond(3, 511, 511, 1'b0);
        lit("x_pulses_park", xcnt - bx, 5);
        lit("y_pulses_park", ycnt - by, 5);
        lit("finish_flag", fin, 1);
        lit("trace_run1", test, TRACE_RUN1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_idle();
        lit("busy_idle", busy, 0);

        // Run 2: zero-distance waypoint, then abort while waiting at (2,0)
        start_run();
        respond(2, 2, 0, 1'b0);
        respond(1, 2, 0, 1'b0);
        lit("zero_move_len", last_move_len, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc_busy();
        start = 1'b0;
        cyc_busy();
        pos_if.iDone = 1'b1;
        pos_if.iX = 9'd7;
        pos_if.iY = 9'd7;
        pos_if.iDown = 1'b1;
        bx = xcnt;
        park();
        pos_if.iDone = 1'b0;
        lit("abort_x_pulses", xcnt - bx, 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_idle();

        // Run 3: abort sampled in REQ while already home
        start_run();
        start = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        park();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_idle();

        // Run 4: reset in the middle of a move, then verify position restarted at home
        start_run();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        pos_if.iDone = 1'b1;
        pos_if.iX = 9'd4;
        pos_if.iY = 9'd4;
        pos_if.iDown = 1'b1;
        cyc_busy();
        pos_if.iDone = 1'b0;
        trace_inc();
        move(4, 4, 6);
        rst_n = 1'b0;
        start = 1'b0;
        m_x = 0; m_y = 0; m_pen = 1'b0; m_xd = 1'b0; m_yd = 1'b0; m_test = 0;
        cyc_idle();
        cyc_idle();
        rst_n = 1'b1;
        cyc_idle();
        start_run();
        bx = xcnt; by = ycnt;
        respond(1, 1, 0, 1'b0);
        lit("x_pulses_after_reset", xcnt - bx, 1);
        lit("y_pulses_after_reset", ycnt - by, 0);
        respond(1, 511, 511, 1'b0);
        start = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_idle();

        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pos_stepper_ctrl.md
# pos_stepper_ctrl

Pen-plotter motion controller that sits downstream of the flash-to-position converter. It pulls pen waypoints (X, Y, pen-down flag) over the position request/done handshake and drives two step/direction stepper axes plus a pen servo level. At the end-of-drawing sentinel it raises the pen, parks the head at (0,0) and reports completion.

## Interface
- STEP_HALF, 2500: clock cycles per step-pulse half period (≥1); one step period = 2·STEP_HALF cycles.
- PEN_SETTLE, 500000: cycles the pen servo is allowed to settle after any pen level change (≥1).
- iCLK  in  1  system clock.
- iRST  in  1  reset. One clock; reset is asynchronous and active-low.
- iStart  in  1  level; high = run drawing, low = abort/park.
- oPOS_REQUEST  out  1  one-cycle request for the next waypoint.
- iX  in  9  waypoint X, valid when iDone=1.
- iY  in  9  waypoint Y, valid when iDone=1.
- iDone  in  1  one-cycle response strobe; may arrive ≥1 cycle after request.
- iDown  in  1  pen level to apply after reaching waypoint.
- oX_STEP, oY_STEP  out  1  step pulses.
- oX_DIR, oY_DIR  out  1  1 = increment coordinate, 0 = decrement.
- oPEN  out  1  pen servo level, 1 = down.
- oBusy  out  1  high in every state except IDLE and FIN.
- oFinish  out  1  level, high in FIN.
- oTest  out  15  debug waypoint counter (see Configuration).

## Operation
- Internal position registers curX, curY (9 bits each), reset to 0; home assumed at reset.
- States: IDLE, REQ, WAIT, MOVE, PEN, PARK_PEN, PARK_MOVE, FIN.
- IDLE: iStart=1 → REQ.
- REQ: oPOS_REQUEST=1 for exactly one cycle → WAIT.
- WAIT: request low; on iDone capture tgtX=iX, tgtY=iY, tgtDown=iDown. Sentinel (iX=511 and iY=511) → PARK_PEN; else → MOVE.
- MOVE: pen unchanged; both axes step concurrently, each only while cur≠tgt. Exit to PEN when curX=tgtX and curY=tgtY.
- PEN: if oPEN=tgtDown → REQ next cycle; else set oPEN=tgtDown, wait PEN_SETTLE cycles, → REQ.
- PARK_PEN: oPEN=0; settle PEN_SETTLE cycles only if pen was down; → PARK_MOVE with target (0,0).
- PARK_MOVE: MOVE rules toward (0,0); done → FIN.
- FIN: oFinish=1; iStart=0 → IDLE.
- Abort: iStart=0 in REQ or WAIT → PARK_PEN. In MOVE/PEN the current waypoint completes first; abort is then sampled at REQ. A strobe arriving after abort is ignored.
- iDone outside WAIT is ignored.
- Arithmetic: cur±1 is 9-bit, never wraps, since stepping stops at equality. Targets 0..510 are accepted unclamped.

## Timing
- Reset values: oPOS_REQUEST=0, oX_STEP=oY_STEP=0, oX_DIR=oY_DIR=0, oPEN=0, oBusy=0, oFinish=0, oTest=0, state IDLE.
- Request-to-capture latency: REQ at cycle t; earliest iDone at t+1.
- MOVE entry cycle: DIR outputs set (tgt>cur → 1, tgt<cur → 0, equal → unchanged); no pulse. Step periods start the next cycle.
- Each period: STEP high for STEP_HALF cycles, then low for STEP_HALF cycles. cur updates on the last cycle of the period.
- DIR is stable for the whole MOVE.
- Zero-distance move: MOVE lasts exactly 1 cycle.
- Move time = 1 + 2·STEP_HALF·max(|dX|,|dY|) cycles.
- Reset mid-operation: all outputs return to reset values immediately; cur resets to (0,0).

## Configuration
- POS_TRACE_EN defined: oTest increments by 1 on each captured non-sentinel waypoint, saturates at 32767, and clears on the IDLE→REQ transition.
- POS_TRACE_EN undefined: oTest is tied to 0 and the counter is not built.

## Test plan
Parameters for all scenarios: STEP_HALF=2, PEN_SETTLE=4.
- Reset then iStart=1: oPOS_REQUEST pulses one cycle after IDLE exit; all outputs 0 before that.
- Respond with (3,1,down=1) after 5 cycles → X_DIR=1, Y_DIR=1; 3 X pulses and 1 Y pulse, each 2 high/2 low; MOVE lasts 13 cycles; oPEN rises; next request follows 4 cycles later.
- From (3,1), respond (0,1,0) → X_DIR=0, 3 X pulses, no Y pulses; oPEN falls and settles; curX=0.
- Respond (511,511) with pen down at (5,5) → oPEN=0, 4 settle cycles, 5 decrementing pulses per axis, oFinish=1; iStart=0 → IDLE, oBusy=0.
- iStart=0 while in WAIT at (2,0) → park; a late iDone is ignored; oFinish=1 after home is reached.
- With POS_TRACE_EN: 3 waypoints then the sentinel → oTest=3; without the macro, oTest stays 0.
